// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file types and constants for the write-back
// arbiter slice. Widths and reset constants mirror the core-wide definitions
// (register address bus, register data bus, zero word, NOP register address).
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_W      = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      reg_t;

   localparam reg_addr_t NOP_REG_ADDR = '0;
   localparam reg_t      ZERO_WORD    = '0;
   localparam logic      ENABLE       = 1'b1;
   localparam logic      DISABLE      = 1'b0;

   // One pending register write: destination and data
   typedef struct packed {
      reg_addr_t wd;
      reg_t      wdata;
   } wb_entry_t;

   // Occupancy of the holding FIFO as seen by the stall logic
   typedef enum logic [1:0] {
      OCC_EMPTY    = 2'd0,
      OCC_HOLD     = 2'd1,
      OCC_NEARFULL = 2'd2
   } occ_state_t;

   // A write request is only real if it targets something other than x0
   function automatic logic is_live(input logic wreg, input reg_addr_t wd);
      return wreg && (wd != NOP_REG_ADDR);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular holding buffer for register writes that lost write-port
// arbitration. Strict arrival order, pointers wrap modulo DEPTH.
// With WB_FWD_EN defined, the entries are also exposed ordered oldest-first
// so the arbiter can search them for forwarding.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  wb_entry_t  push_entry,
   output wb_entry_t  head,
   output logic [3:0] cnt
`ifdef WB_FWD_EN
   ,
   output wb_entry_t  by_age [DEPTH]
`endif
);

   localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Entry storage: payload only, left unreset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // Pointers and occupancy; simultaneous push and pop keeps cnt unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      cnt <= cnt + 4'd1;
         else if (pop && !push) cnt <= cnt - 4'd1;
      end
   end

   assign head = mem[rd_ptr];

`ifdef WB_FWD_EN
   // Age-ordered view: index 0 is the head (oldest)
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         by_age[i] = mem[PTR_W'((int'(rd_ptr) + i) % DEPTH)];
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write-port arbiter between the MEM stage
// and the load-return path. Priority: load return, FIFO head, MEM. A losing
// MEM write is parked in wb_fifo and written back in a later load-free cycle.
// Upstream is stalled while the FIFO holds DEPTH-1 or more entries.
// Optional feature macro WB_FWD_EN adds a combinational forwarding lookup
// (fwd_raddr / fwd_hit / fwd_data) over the FIFO and the wb_* register.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_wreg,
   input  reg_addr_t  mem_wd,
   input  reg_t       mem_wdata,
   input  logic       l_wreg,
   input  reg_addr_t  l_wd,
   input  reg_t       l_wdata,
   output logic       wb_wreg,
   output reg_addr_t  wb_wd,
   output reg_t       wb_wdata,
   output logic       stall_req,
   output logic [3:0] fifo_cnt,
   output logic       overflow
`ifdef WB_FWD_EN
   ,
   input  reg_addr_t  fwd_raddr,
   output logic       fwd_hit,
   output reg_t       fwd_data
`endif
);

   localparam logic [3:0] NEAR_CNT = 4'(DEPTH - 1);

   occ_state_t occ_state;
   wb_entry_t  head;
   wb_entry_t  mem_entry;
   wb_entry_t  win_p0;
   logic       vld_p0;
   logic       l_live;
   logic       m_live;
   logic       fifo_busy;
   logic       push;
   logic       pop;
   logic [3:0] cnt_next;

`ifdef WB_FWD_EN
   wb_entry_t  by_age [DEPTH];
`endif

   assign l_live    = is_live(l_wreg, l_wd);
   assign m_live    = is_live(mem_wreg, mem_wd);
   assign fifo_busy = (fifo_cnt != 4'd0);
   assign mem_entry = '{wd: mem_wd, wdata: mem_wdata};
   assign stall_req = (occ_state == OCC_NEARFULL);

   // Arbitration: pick the winner, decide pop of the head and push of a losing MEM
   always_comb begin
      vld_p0 = DISABLE;
      win_p0 = '{wd: NOP_REG_ADDR, wdata: ZERO_WORD};
      pop    = 1'b0;
      push   = 1'b0;
      if (l_live) begin
         vld_p0 = ENABLE;
         win_p0 = '{wd: l_wd, wdata: l_wdata};
      end else if (fifo_busy) begin
         vld_p0 = ENABLE;
         win_p0 = head;
         pop    = 1'b1;
      end else if (m_live) begin
         vld_p0 = ENABLE;
         win_p0 = mem_entry;
      end
      // A MEM loser is parked unless upstream ignored the stall, then it is dropped
      if (m_live && (l_live || fifo_busy) && !stall_req) push = 1'b1;
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .push_entry (mem_entry),
      .head       (head),
      .cnt        (fifo_cnt)
`ifdef WB_FWD_EN
      ,
      .by_age     (by_age)
`endif
   );

   assign cnt_next = fifo_cnt + {3'd0, push} - {3'd0, pop};

   // Occupancy FSM tracking the count after this cycle's push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_state <= OCC_EMPTY;
      end else if (cnt_next == 4'd0) begin
         occ_state <= OCC_EMPTY;
      end else if (cnt_next >= NEAR_CNT) begin
         occ_state <= OCC_NEARFULL;
      end else begin
         occ_state <= OCC_HOLD;
      end
   end

   // ---- stage boundary: arbitration result -> regfile write port ----
   // Write-port register; address/data hold when nothing wins
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_wreg  <= DISABLE;
         wb_wd    <= NOP_REG_ADDR;
         wb_wdata <= ZERO_WORD;
      end else begin
         wb_wreg <= vld_p0;
         if (vld_p0) begin
            wb_wd    <= win_p0.wd;
            wb_wdata <= win_p0.wdata;
         end
      end
   end

   // Sticky protocol-violation flag: MEM presented a write during stall
   always_ff @(posedge clk) begin
      if (rst)                        overflow <= 1'b0;
      else if (mem_wreg && stall_req) overflow <= 1'b1;
   end

`ifdef WB_FWD_EN
   // Forwarding lookup: wb register first, then FIFO oldest to youngest so the newest match wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = ZERO_WORD;
      if (wb_wreg && (wb_wd == fwd_raddr)) begin
         fwd_hit  = 1'b1;
         fwd_data = wb_wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if ((4'(i) < fifo_cnt) && (by_age[i].wd == fwd_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = by_age[i].wdata;
         end
      end
      if (fwd_raddr == NOP_REG_ADDR) begin
         fwd_hit  = 1'b0;
         fwd_data = ZERO_WORD;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. Two instances: DEPTH=2 (u_a)
// and DEPTH=4 (u_b). Expected regfile writes are queued as stimulus is issued;
// a per-instance monitor pops and compares on every wb_wreg pulse.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       mem_wreg_a, l_wreg_a, wb_wreg_a, stall_a, ovf_a;
   reg_addr_t  mem_wd_a, l_wd_a, wb_wd_a;
   reg_t       mem_wdata_a, l_wdata_a, wb_wdata_a;
   logic [3:0] cnt_a;
   logic       mem_wreg_b, l_wreg_b, wb_wreg_b, stall_b, ovf_b;
   reg_addr_t  mem_wd_b, l_wd_b, wb_wd_b;
   reg_t       mem_wdata_b, l_wdata_b, wb_wdata_b;
   logic [3:0] cnt_b;
`ifdef WB_FWD_EN
   reg_addr_t  fwd_raddr_a, fwd_raddr_b;
   logic       fwd_hit_a, fwd_hit_b;
   reg_t       fwd_data_a, fwd_data_b;
`endif

   wb_arbiter #(.DEPTH(2)) u_a (
      .clk(clk), .rst(rst),
      .mem_wreg(mem_wreg_a), .mem_wd(mem_wd_a), .mem_wdata(mem_wdata_a),
      .l_wreg(l_wreg_a), .l_wd(l_wd_a), .l_wdata(l_wdata_a),
      .wb_wreg(wb_wreg_a), .wb_wd(wb_wd_a), .wb_wdata(wb_wdata_a),
      .stall_req(stall_a), .fifo_cnt(cnt_a), .overflow(ovf_a)
`ifdef WB_FWD_EN
      , .fwd_raddr(fwd_raddr_a), .fwd_hit(fwd_hit_a), .fwd_data(fwd_data_a)
`endif
   );

   wb_arbiter #(.DEPTH(4)) u_b (
      .clk(clk), .rst(rst),
      .mem_wreg(mem_wreg_b), .mem_wd(mem_wd_b), .mem_wdata(mem_wdata_b),
      .l_wreg(l_wreg_b), .l_wd(l_wd_b), .l_wdata(l_wdata_b),
      .wb_wreg(wb_wreg_b), .wb_wd(wb_wd_b), .wb_wdata(wb_wdata_b),
      .stall_req(stall_b), .fifo_cnt(cnt_b), .overflow(ovf_b)
`ifdef WB_FWD_EN
      , .fwd_raddr(fwd_raddr_b), .fwd_hit(fwd_hit_b), .fwd_data(fwd_data_b)
`endif
   );

   int        n_cmp = 0;
   int        n_bad = 0;
   wb_entry_t q_a [$];
   wb_entry_t q_b [$];
   wb_entry_t e_a, e_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input int sel, input reg_addr_t wd, input reg_t d);
      if (sel == 0) q_a.push_back('{wd: wd, wdata: d});
      else          q_b.push_back('{wd: wd, wdata: d});
   endtask

   task automatic idle_inputs();
      mem_wreg_a = 1'b0; mem_wd_a = '0; mem_wdata_a = '0;
      l_wreg_a   = 1'b0; l_wd_a   = '0; l_wdata_a   = '0;
      mem_wreg_b = 1'b0; mem_wd_b = '0; mem_wdata_b = '0;
      l_wreg_b   = 1'b0; l_wd_b   = '0; l_wdata_b   = '0;
   endtask

   // One clock of stimulus on the selected instance; returns 1 time unit after the edge
   task automatic cyc(input int sel,
                      input logic mw, input reg_addr_t mwd, input reg_t md,
                      input logic lw, input reg_addr_t lwd, input reg_t ld);
      if (sel == 0) begin
         mem_wreg_a = mw; mem_wd_a = mwd; mem_wdata_a = md;
         l_wreg_a   = lw; l_wd_a   = lwd; l_wdata_a   = ld;
      end else begin
         mem_wreg_b = mw; mem_wd_b = mwd; mem_wdata_b = md;
         l_wreg_b   = lw; l_wd_b   = lwd; l_wdata_b   = ld;
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic idle(input int sel);
      cyc(sel, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   // Monitor for the DEPTH=2 instance
   always @(negedge clk) begin
      if (wb_wreg_a === 1'b1) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u_a_unexpected_write: got x%0d=0x%0h, expected no write (t=%0t)",
                     wb_wd_a, wb_wdata_a, $time);
         end else begin
            e_a = q_a.pop_front();
            chk("u_a_wb_wd", 32'(wb_wd_a), 32'(e_a.wd));
            chk("u_a_wb_wdata", wb_wdata_a, e_a.wdata);
         end
      end
   end

   // Monitor for the DEPTH=4 instance
   always @(negedge clk) begin
      if (wb_wreg_b === 1'b1) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u_b_unexpected_write: got x%0d=0x%0h, expected no write (t=%0t)",
                     wb_wd_b, wb_wdata_b, $time);
         end else begin
            e_b = q_b.pop_front();
            chk("u_b_wb_wd", 32'(wb_wd_b), 32'(e_b.wd));
            chk("u_b_wb_wdata", wb_wdata_b, e_b.wdata);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      idle_inputs();
`ifdef WB_FWD_EN
      fwd_raddr_a = '0;
      fwd_raddr_b = '0;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_wb_wreg", 32'(wb_wreg_a), 32'd0);
      chk("rst_wb_wd", 32'(wb_wd_a), 32'd0);
      chk("rst_wb_wdata", wb_wdata_a, 32'd0);
      chk("rst_cnt", 32'(cnt_a), 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      chk("rst_overflow", 32'(ovf_a), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);
      chk("rst_stall_b", 32'(stall_b), 32'd0);
      idle(0);

      // MEM alone, FIFO empty: direct write next cycle
      expect_wr(0, 5'd5, 32'h11);
      cyc(0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
      chk("mem_alone_cnt", 32'(cnt_a), 32'd0);
      chk("mem_alone_stall", 32'(stall_a), 32'd0);

      // Load and MEM collide: load first, MEM parked then drained
      expect_wr(0, 5'd6, 32'hAA);
      expect_wr(0, 5'd7, 32'hBB);
      cyc(0, 1'b1, 5'd7, 32'hBB, 1'b1, 5'd6, 32'hAA);
      chk("collide_cnt", 32'(cnt_a), 32'd1);
      chk("collide_stall", 32'(stall_a), 32'd1);
      idle(0);
      chk("drain_cnt", 32'(cnt_a), 32'd0);
      chk("drain_stall", 32'(stall_a), 32'd0);

      // Four load cycles in a row; parked x8 waits for the first load-free cycle
      expect_wr(0, 5'd10, 32'h100);
      expect_wr(0, 5'd11, 32'h101);
      expect_wr(0, 5'd12, 32'h102);
      expect_wr(0, 5'd13, 32'h103);
      expect_wr(0, 5'd8,  32'h88);
      cyc(0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'h100);
      chk("park_cnt0", 32'(cnt_a), 32'd1);
      for (int i = 1; i < 4; i++) begin
         cyc(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(10 + i), 32'(32'h100 + i));
         chk("park_cnt_hold", 32'(cnt_a), 32'd1);
      end
      idle(0);
      chk("park_cnt_drained", 32'(cnt_a), 32'd0);

      // Writes to x0 are swallowed
      cyc(0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
      cyc(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h66);
      chk("x0_cnt", 32'(cnt_a), 32'd0);

      // Protocol violation: MEM x9 during stall with a load returning
      expect_wr(0, 5'd20, 32'h20);
      expect_wr(0, 5'd22, 32'h22);
      expect_wr(0, 5'd23, 32'h23);
      cyc(0, 1'b1, 5'd21, 32'h21, 1'b1, 5'd20, 32'h20);
      chk("ovf_pre_stall", 32'(stall_a), 32'd1);
      chk("ovf_pre_flag", 32'(ovf_a), 32'd0);
      cyc(0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd22, 32'h22);
      chk("ovf_set", 32'(ovf_a), 32'd1);
      chk("ovf_dropped_cnt", 32'(cnt_a), 32'd1);
      cyc(0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd23, 32'h23);
      chk("ovf_sticky", 32'(ovf_a), 32'd1);
      chk("ovf_cnt_hold", 32'(cnt_a), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst2_overflow", 32'(ovf_a), 32'd0);
      chk("rst2_cnt", 32'(cnt_a), 32'd0);
      chk("rst2_stall", 32'(stall_a), 32'd0);
      chk("rst2_wb_wreg", 32'(wb_wreg_a), 32'd0);
      idle(0);
      idle(0);
      chk("rst2_cnt_after", 32'(cnt_a), 32'd0);

      // DEPTH=4: three collisions fill to 3, stall at 3, then ordered drain
      expect_wr(1, 5'd1, 32'h101);
      expect_wr(1, 5'd3, 32'h303);
      expect_wr(1, 5'd5, 32'h505);
      expect_wr(1, 5'd2, 32'h202);
      expect_wr(1, 5'd4, 32'h404);
      expect_wr(1, 5'd6, 32'h606);
      cyc(1, 1'b1, 5'd2, 32'h202, 1'b1, 5'd1, 32'h101);
      chk("d4_cnt1", 32'(cnt_b), 32'd1);
      chk("d4_stall1", 32'(stall_b), 32'd0);
      cyc(1, 1'b1, 5'd4, 32'h404, 1'b1, 5'd3, 32'h303);
      chk("d4_cnt2", 32'(cnt_b), 32'd2);
      chk("d4_stall2", 32'(stall_b), 32'd0);
      cyc(1, 1'b1, 5'd6, 32'h606, 1'b1, 5'd5, 32'h505);
      chk("d4_cnt3", 32'(cnt_b), 32'd3);
      chk("d4_stall3", 32'(stall_b), 32'd1);
      idle(1);
      chk("d4_drain_cnt2", 32'(cnt_b), 32'd2);
      chk("d4_drain_stall", 32'(stall_b), 32'd0);
      idle(1);
      chk("d4_drain_cnt1", 32'(cnt_b), 32'd1);
      idle(1);
      chk("d4_drain_cnt0", 32'(cnt_b), 32'd0);

      // Pointer wrap plus simultaneous pop and push
      expect_wr(1, 5'd7,  32'h707);
      expect_wr(1, 5'd9,  32'h909);
      expect_wr(1, 5'd8,  32'h808);
      expect_wr(1, 5'd10, 32'hA10);
      expect_wr(1, 5'd12, 32'hC12);
      cyc(1, 1'b1, 5'd8, 32'h808, 1'b1, 5'd7, 32'h707);
      chk("wrap_cnt1", 32'(cnt_b), 32'd1);
      cyc(1, 1'b1, 5'd10, 32'hA10, 1'b1, 5'd9, 32'h909);
      chk("wrap_cnt2", 32'(cnt_b), 32'd2);
      cyc(1, 1'b1, 5'd12, 32'hC12, 1'b0, 5'd0, 32'h0);
      chk("pushpop_cnt", 32'(cnt_b), 32'd2);
      idle(1);
      chk("wrap_drain_cnt1", 32'(cnt_b), 32'd1);
      idle(1);
      chk("wrap_drain_cnt0", 32'(cnt_b), 32'd0);

`ifdef WB_FWD_EN
      // Forwarding: x3 parked twice, newest wins; x0 never hits
      expect_wr(1, 5'd17, 32'hF1);
      expect_wr(1, 5'd18, 32'hF2);
      expect_wr(1, 5'd3,  32'h1);
      expect_wr(1, 5'd3,  32'h2);
      cyc(1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd17, 32'hF1);
      cyc(1, 1'b1, 5'd3, 32'h2, 1'b1, 5'd18, 32'hF2);
      fwd_raddr_b = 5'd3;
      #1;
      chk("fwd_x3_hit", 32'(fwd_hit_b), 32'd1);
      chk("fwd_x3_data", fwd_data_b, 32'h2);
      fwd_raddr_b = 5'd18;
      #1;
      chk("fwd_wbreg_hit", 32'(fwd_hit_b), 32'd1);
      chk("fwd_wbreg_data", fwd_data_b, 32'hF2);
      fwd_raddr_b = 5'd0;
      #1;
      chk("fwd_x0_hit", 32'(fwd_hit_b), 32'd0);
      fwd_raddr_b = 5'd17;
      #1;
      chk("fwd_stale_hit", 32'(fwd_hit_b), 32'd0);
      fwd_raddr_b = 5'd0;
      idle(1);
      idle(1);
      chk("fwd_drain_cnt", 32'(cnt_b), 32'd0);
`endif

      idle(0);
      idle(1);
      chk("u_a_pending_writes", 32'(q_a.size()), 32'd0);
      chk("u_b_pending_writes", 32'(q_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter between the MEM stage and the load-return path of the RISC-V core. It replaces the fixed load-wins merge at the MEM/WB boundary with a scheduled, lossless one. A pipeline result that loses arbitration to a returning load is parked in a small FIFO and written back later, and upstream is stalled only when the FIFO is nearly full. Outputs drive the single regfile write port directly.

## Interface
- `DEPTH`, 2: holding-FIFO entries; legal range 2..8.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_wreg` in 1: MEM stage has a register write this cycle.
- `mem_wd` in `RegAddrBus`: MEM destination register.
- `mem_wdata` in `RegBus`: MEM write data.
- `l_wreg` in 1: load data returning this cycle.
- `l_wd` in `RegAddrBus`: load destination register.
- `l_wdata` in `RegBus`: load data.
- `wb_wreg` out 1: regfile write enable (registered).
- `wb_wd` out `RegAddrBus`: regfile write address (registered).
- `wb_wdata` out `RegBus`: regfile write data (registered).
- `stall_req` out 1: upstream must not present `mem_wreg` while high.
- `fifo_cnt` out 4: current FIFO occupancy.
- `overflow` out 1: sticky flag; protocol violation seen.

## Operation
- A request whose destination is x0 is accepted and discarded. It is never written and never pushed.
- Priority each cycle: load return, then FIFO head, then MEM.
- Winner is registered onto `wb_*`. If no winner, `wb_wreg`=0 and `wb_wd`/`wb_wdata` hold their previous values.
- If MEM loses, it is pushed at the FIFO tail in the same cycle.
- If the FIFO head loses, it stays at the head.
- If the FIFO head wins, it is popped. A MEM push in the same cycle is allowed and is written behind it.
- FIFO order is strictly in arrival order. Pointers wrap modulo `DEPTH`.
- Occupancy states:
  - EMPTY: cnt=0.
  - HOLD: 0<cnt<DEPTH-1.
  - NEARFULL: cnt≥DEPTH-1.
  - Transitions follow cnt after push/pop; push and pop in the same cycle leave cnt unchanged.
- `stall_req` = (cnt ≥ DEPTH-1). It is combinational from registered cnt. With at most one push per cycle, this keeps the FIFO from overflowing.
- If `mem_wreg`=1 while `stall_req`=1:
  - The MEM request is dropped unless it wins arbitration outright (FIFO empty and no load).
  - `overflow` is set and stays set until `rst`.
- Simultaneous load return and FIFO head: the load wins, and the FIFO drains on the next cycle without a load return.

## Timing
- Latency is one cycle, input to `wb_*`, for any winner.
- A parked entry is written back no earlier than the first cycle with `l_wreg`=0.
- `stall_req` rises in the cycle after the push that makes cnt=DEPTH-1.
- `stall_req` falls in the cycle after the pop that makes cnt<DEPTH-1.
- Reset values: `wb_wreg`=0, `wb_wd`=`NOPRegAddr`, `wb_wdata`=`ZeroWord`, cnt=0, `stall_req`=0, `overflow`=0, FIFO pointers=0.
- Reset mid-operation discards all parked entries. No write is issued in the cycle after reset.

## Configuration
- `WB_FWD_EN` defined: adds the following forwarding ports.
  - `fwd_raddr` in `RegAddrBus`.
  - `fwd_hit` out 1.
  - `fwd_data` out `RegBus`.
- The lookup is combinational. It searches the FIFO from youngest entry to oldest, then the `wb_*` register.
- `fwd_hit`=1 with the newest matching data. `fwd_raddr`=0 never hits.
- `WB_FWD_EN` undefined: these ports and their search logic are absent. The decoder must stall on any pending destination.

## Structure
- `RegAddrBus`, `RegBus`, `ZeroWord`, `NOPRegAddr`, `Enable`/`Disable` come from the shared `defines.v`. No new widths are introduced.
- Sub-module `wb_fifo`:
  - Circular buffer holding {wd, wdata}.
  - Push/pop, head, cnt, wrapping pointers.
  - With `WB_FWD_EN`, also exposes an entry-array read-out for the forwarding search.

## Test plan
- MEM x5=0x11 alone, FIFO empty → next cycle `wb_wreg`=1, `wb_wd`=5, `wb_wdata`=0x11; `fifo_cnt`=0.
- Same cycle: load x6=0xAA and MEM x7=0xBB → cycle+1 writes x6=0xAA, cnt=1, `stall_req`=1 (DEPTH=2). Cycle+2, no load: writes x7=0xBB, cnt=0, `stall_req`=0.
- Load returns every cycle for 4 cycles with one MEM x8 parked → x8 written only in the first load-free cycle; order is preserved.
- DEPTH=4: three back-to-back load+MEM collisions → cnt goes 1,2,3; `stall_req` high at cnt=3. Entries then drain in order with wrap-around.
- MEM x9 asserted while `stall_req`=1 and a load returns → request dropped, `overflow`=1; `rst` clears it and cnt.
- `WB_FWD_EN`: x3 parked twice (0x1, then 0x2), `fwd_raddr`=3 → `fwd_hit`=1, `fwd_data`=0x2; `fwd_raddr`=0 → `fwd_hit`=0.
